sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset.
REQ-002 DATA_WIDTH, default 32, SHALL set the data word width.
REQ-003 ADDR_WIDTH, default 2, SHALL set DEPTH = 2**ADDR_WIDTH; legal range 1..10.
REQ-004 AFULL_THRESH, default DEPTH-1, SHALL set the almost_full threshold; legal range 1..DEPTH.
REQ-005 AEMPTY_THRESH, default 1, SHALL set the almost_empty threshold; legal range 0..DEPTH-1.
REQ-006 FWFT, default 0, SHALL select read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-007 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  async reset, active-high.
- flush  in  1  synchronous clear of contents and pointers.
- winc  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- rinc  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Function
REQ-008 A write SHALL be accepted on a clk edge when winc=1 and wfull=0; wdata is stored at wptr and wptr increments, modulo DEPTH.
REQ-009 A read SHALL be accepted on a clk edge when rinc=1 and rempty=0; rptr increments, modulo DEPTH.
REQ-010 Both pointers SHALL be ADDR_WIDTH+1-bit binary; full = MSBs differ and low bits are equal; empty = pointers are equal.
REQ-011 count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds DEPTH.
REQ-012 wfull, rempty, almost_full and almost_empty SHALL be decoded combinationally from the registered pointers/count, so they update the cycle after the causing edge.
REQ-013 When full and winc=rinc=1, the read SHALL be accepted, the write rejected and overflow set.
REQ-014 When empty and winc=rinc=1, the write SHALL be accepted, the read rejected and underflow set; in FWFT=1 the written word becomes visible on rdata the next cycle.
REQ-015 FWFT=0: rdata SHALL be a register loaded with mem[rptr] on an accepted read, valid the cycle after the edge, and held otherwise.
REQ-016 FWFT=1: rdata SHALL equal mem[rptr] combinationally whenever rempty=0, with zero read latency; it is don't-care when empty.
REQ-017 overflow/underflow SHALL remain set until rst or flush.
REQ-018 flush=1 SHALL, on the edge, zero pointers, count, overflow and underflow; it takes priority over winc/rinc that cycle; memory contents are not cleared.

Reset
REQ-019 While rst=1, pointers, count, overflow, underflow and the FWFT=0 rdata register SHALL be 0, so rempty=1, wfull=0, almost_empty=1 and almost_full=0 (AFULL_THRESH>0).
REQ-020 Assertion of rst mid-operation SHALL discard all contents immediately; memory needs no reset.
REQ-021 After deassertion, the first accepted write SHALL occur on the first clk edge with winc=1.

Structure
REQ-022 Package fifo_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and the mode enum (FIFO_STD, FIFO_FWFT).
REQ-023 Storage SHALL be a sub-module fifo_mem (1 write port, 1 async read port, no reset); pointer, flag and count logic lives in sync_fifo_flags.

Verification
REQ-024 The bench SHALL cover these scenarios (DATA_WIDTH=32, ADDR_WIDTH=2):
- Reset, then write 0xA0..0xA3 -> wfull=1, count=4, almost_full=1; fifth write 0xA4 -> overflow=1, count=4.
- FWFT=0, drain 4 -> rdata A0,A1,A2,A3 each the cycle after its rinc; rempty=1; extra rinc -> underflow=1.
- FWFT=1, write 0x55 into empty -> next cycle rempty=0 and rdata=0x55 before any rinc.
- Full, winc=rinc=1 with wdata 0xFF -> count=3, overflow=1, 0xFF never read; wrap: 10 write/read pairs, data in order.
- Count 3 with overflow set, flush=1 plus winc=1 -> count=0, rempty=1, overflow=0, write ignored.
- rst pulsed mid-burst at count 2 -> rempty=1 and count=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants and read-mode enum for the synchronous FIFO with status flags.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 2;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_flags_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  flush;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wfull;
    logic                  rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO: binary pointers, registered count, threshold flags, sticky
// overflow/underflow, selectable registered or first-word-fall-through read.
module sync_fifo_flags import fifo_pkg::*; #(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_flags_if.slave  bus
);
    localparam fifo_mode_e          MODE     = FWFT ? FIFO_FWFT : FIFO_STD;
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wfull_s, rempty_s, wr_acc_s, rd_acc_s, mem_we_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    // Flag decode from registered state only
    always_comb begin
        wfull_s  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
        rempty_s = (wptr_q == rptr_q);
    end

    // Next-state: accept/reject decisions, pointers, occupancy, sticky errors
    always_comb begin
        wr_acc_s    = bus.winc & ~wfull_s & ~bus.flush;
        rd_acc_s    = bus.rinc & ~rempty_s & ~bus.flush;
        mem_we_s    = wr_acc_s;
        wptr_d      = wr_acc_s ? (wptr_q + ONE_C) : wptr_q;
        rptr_d      = rd_acc_s ? (rptr_q + ONE_C) : rptr_q;
        overflow_d  = overflow_q  | (bus.winc & wfull_s);
        underflow_d = underflow_q | (bus.rinc & rempty_s);
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        if (bus.flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            count_d     = count_d;
        end
    end

    // Pointer, count and sticky-error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr_q[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata_s)
    );

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

            // Read register loads only on an accepted read, holds otherwise
            always_comb begin
                if (rd_acc_s) begin
                    rdata_d = mem_rdata_s;
                end else begin
                    rdata_d = rdata_q;
                end
            end

            // Registered read data
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign bus.rdata = rdata_q;
        end else begin : g_fwft
            assign bus.rdata = mem_rdata_s;
        end
    endgenerate

    assign bus.wfull        = wfull_s;
    assign bus.rempty       = rempty_s;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: registered-read and FWFT instances share
// stimulus and are compared each cycle against a queue model of the FIFO.
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        flush = 1'b0;
    logic        winc  = 1'b0;
    logic        rinc  = 1'b0;
    logic [31:0] wdata = 32'h0;
    bit          started = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_flags_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus_std ();
    sync_fifo_flags_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus_fw ();

    assign bus_std.flush = flush;
    assign bus_std.winc  = winc;
    assign bus_std.wdata = wdata;
    assign bus_std.rinc  = rinc;
    assign bus_fw.flush  = flush;
    assign bus_fw.winc   = winc;
    assign bus_fw.wdata  = wdata;
    assign bus_fw.rinc   = rinc;

    sync_fifo_flags #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(1'b0)) u_std (
        .clk (clk), .rst (rst), .bus (bus_std.slave)
    );
    sync_fifo_flags #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(1'b1)) u_fw (
        .clk (clk), .rst (rst), .bus (bus_fw.slave)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus sticky errors and the registered read word
    logic [31:0] mq [$];
    bit          m_ovf, m_unf;
    logic [31:0] m_rdata;

    always @(posedge clk or posedge rst) begin : model
        bit was_full, was_empty;
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_rdata = 32'h0;
        end else if (flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (winc && was_full)  m_ovf = 1'b1;
            if (rinc && was_empty) m_unf = 1'b1;
            if (rinc && !was_empty) m_rdata = mq.pop_front();
            if (winc && !was_full) mq.push_back(wdata);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        int sz;
        if (started) begin
            sz = mq.size();
            check("std.count",  64'(bus_std.count),      64'(sz));
            check("std.wfull",  64'(bus_std.wfull),      64'(sz == DEPTH));
            check("std.rempty", 64'(bus_std.rempty),     64'(sz == 0));
            check("std.afull",  64'(bus_std.almost_full),  64'(sz >= DEPTH - 1));
            check("std.aempty", 64'(bus_std.almost_empty), 64'(sz <= 1));
            check("std.ovf",    64'(bus_std.overflow),   64'(m_ovf));
            check("std.unf",    64'(bus_std.underflow),  64'(m_unf));
            check("std.rdata",  64'(bus_std.rdata),      64'(m_rdata));
            check("fw.count",   64'(bus_fw.count),       64'(sz));
            check("fw.wfull",   64'(bus_fw.wfull),       64'(sz == DEPTH));
            check("fw.rempty",  64'(bus_fw.rempty),      64'(sz == 0));
            check("fw.ovf",     64'(bus_fw.overflow),    64'(m_ovf));
            check("fw.unf",     64'(bus_fw.underflow),   64'(m_unf));
            if (sz > 0) check("fw.rdata", 64'(bus_fw.rdata), 64'(mq[0]));
        end
    end

    // One clock of stimulus: drive at a falling edge, return at the next one
    task automatic cyc(input bit w, input logic [31:0] d, input bit r, input bit f);
        winc  = w;
        wdata = d;
        rinc  = r;
        flush = f;
        @(negedge clk);
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #1 started = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.count",  64'(bus_std.count), 64'd0);
        check("rst.rempty", 64'(bus_std.rempty), 64'd1);
        check("rst.wfull",  64'(bus_std.wfull), 64'd0);
        check("rst.aempty", 64'(bus_std.almost_empty), 64'd1);
        check("rst.afull",  64'(bus_std.almost_full), 64'd0);
        check("rst.rdata",  64'(bus_std.rdata), 64'd0);
        rst = 1'b0;

        // Fill, then one rejected write
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            if (i == 0) check("first_wr.count", 64'(bus_std.count), 64'd1);
        end
        check("fill.wfull", 64'(bus_std.wfull), 64'd1);
        check("fill.count", 64'(bus_std.count), 64'd4);
        check("fill.afull", 64'(bus_std.almost_full), 64'd1);
        check("fill.fw_rdata", 64'(bus_fw.rdata), 64'hA0);
        cyc(1'b1, 32'hA4, 1'b0, 1'b0);
        check("ovf.flag",  64'(bus_std.overflow), 64'd1);
        check("ovf.count", 64'(bus_std.count), 64'd4);

        // Drain in order, then one rejected read
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            check("drain.rdata", 64'(bus_std.rdata), 64'hA0 + 64'(i));
        end
        check("drain.rempty", 64'(bus_std.rempty), 64'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("unf.flag", 64'(bus_std.underflow), 64'd1);
        check("unf.rdata_held", 64'(bus_std.rdata), 64'hA3);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check("flush.ovf", 64'(bus_std.overflow), 64'd0);
        check("flush.unf", 64'(bus_fw.underflow), 64'd0);

        // Simultaneous write/read into empty: write wins, FWFT shows it at once
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        check("fwft.rempty", 64'(bus_fw.rempty), 64'd0);
        check("fwft.rdata",  64'(bus_fw.rdata), 64'h55);
        check("fwft.unf",    64'(bus_fw.underflow), 64'd1);
        check("fwft.count",  64'(bus_fw.count), 64'd1);

        // Full with simultaneous write/read: read wins, 0xFF dropped
        for (int i = 1; i < 4; i++) cyc(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'hFF, 1'b1, 1'b0);
        check("fullrw.count", 64'(bus_std.count), 64'd3);
        check("fullrw.ovf",   64'(bus_std.overflow), 64'd1);
        check("fullrw.rdata", 64'(bus_std.rdata), 64'h55);
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            check("fullrw.drain", 64'(bus_std.rdata), 64'hB0 + 64'(i));
        end
        check("fullrw.empty", 64'(bus_std.rempty), 64'd1);

        // Pointer wrap with ten paired write/read cycles
        cyc(1'b1, 32'hC0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) cyc(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0);
        check("wrap.rdata",    64'(bus_std.rdata), 64'hC9);
        check("wrap.count",    64'(bus_std.count), 64'd1);
        check("wrap.fw_rdata", 64'(bus_fw.rdata), 64'hCA);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("wrap.last", 64'(bus_std.rdata), 64'hCA);

        // Flush beats a same-cycle write
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("pre_flush.count", 64'(bus_std.count), 64'd3);
        check("pre_flush.ovf",   64'(bus_std.overflow), 64'd1);
        cyc(1'b1, 32'hEE, 1'b0, 1'b1);
        check("flushw.count",  64'(bus_std.count), 64'd0);
        check("flushw.rempty", 64'(bus_std.rempty), 64'd1);
        check("flushw.ovf",    64'(bus_std.overflow), 64'd0);
        cyc(1'b1, 32'h77, 1'b0, 1'b0);
        check("flushw.next_count", 64'(bus_fw.count), 64'd1);
        check("flushw.fw_rdata",   64'(bus_fw.rdata), 64'h77);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("flushw.std_rdata",  64'(bus_std.rdata), 64'h77);

        // Asynchronous reset mid-burst, observed before the next rising edge
        cyc(1'b1, 32'h90, 1'b0, 1'b0);
        cyc(1'b1, 32'h91, 1'b0, 1'b0);
        check("mid.count", 64'(bus_std.count), 64'd2);
        winc  = 1'b1;
        wdata = 32'h92;
        #2 rst = 1'b1;
        #1;
        check("arst.std_count",  64'(bus_std.count), 64'd0);
        check("arst.std_rempty", 64'(bus_std.rempty), 64'd1);
        check("arst.fw_count",   64'(bus_fw.count), 64'd0);
        check("arst.fw_rempty",  64'(bus_fw.rempty), 64'd1);
        check("arst.rdata",      64'(bus_std.rdata), 64'd0);
        @(negedge clk);
        winc = 1'b0;
        rst  = 1'b0;
        cyc(1'b1, 32'hE1, 1'b0, 1'b0);
        check("post_rst.count",    64'(bus_fw.count), 64'd1);
        check("post_rst.fw_rdata", 64'(bus_fw.rdata), 64'hE1);

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
